// File: rtl/mtm_alu_sequencer.sv
// mtm_alu_sequencer: front-end controller for the mtm_Alu_core datapath.
// Accepts A/B/OP/CRC packets over valid/ready, validates them, then either
// returns an error frame or issues the op to the core and returns its result.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   in_valid/in_ready           packet handshake from the deserializer
//   in_a, in_b, in_op, in_crc   packet fields
//   in_err                      deserializer error for this packet
//   core_a, core_b, core_ctl    operands and CTL to the core
//   core_c, core_ctl_out        core result and {0, flags, crc3}
//   out_valid/out_ready         response handshake to the serializer
//   out_c, out_ctl, out_is_err  response payload
//   busy                        not idle
//   op_cnt, err_cnt             completed good / error responses
// Optional feature macro: MTM_ALU_SEQ_STATS_EN enables the two counters;
// when undefined they read 0 and no counter flops exist.
module mtm_alu_sequencer #(
    parameter int unsigned CORE_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [2:0]  in_op,
    input  logic [3:0]  in_crc,
    input  logic        in_err,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    output logic [7:0]  core_ctl,
    input  logic [31:0] core_c,
    input  logic [7:0]  core_ctl_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_c,
    output logic [7:0]  out_ctl,
    output logic        out_is_err,
    output logic        busy,
    output logic [15:0] op_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_e;

    localparam logic [7:0] ERR_DATA = 8'hC9;
    localparam logic [7:0] ERR_CRC  = 8'hA5;
    localparam logic [7:0] ERR_OP   = 8'h93;
    // Idle CTL value: the core passes its flags through untouched.
    localparam logic [7:0] CTL_PASS = 8'hA5;
    localparam logic [3:0] LAT      = 4'(CORE_LAT);

    // Serial CRC, x^4+x+1, init 0, MSB of the vector shifted in first.
    function automatic logic [3:0] crc4(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2:0], 1'b0};
            if (fb) begin
                c = c ^ 4'b0011;
            end
        end
        return c;
    endfunction

    function automatic logic op_legal(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) ||
               (op == 3'b100) || (op == 3'b101);
    endfunction

    state_e      state_q, state_d;
    logic [31:0] pkt_a_q, pkt_a_d;
    logic [31:0] pkt_b_q, pkt_b_d;
    logic [2:0]  pkt_op_q, pkt_op_d;
    logic [3:0]  pkt_crc_q, pkt_crc_d;
    logic        pkt_err_q, pkt_err_d;
    logic [31:0] core_a_q, core_a_d;
    logic [31:0] core_b_q, core_b_d;
    logic [7:0]  core_ctl_q, core_ctl_d;
    logic [3:0]  wait_q, wait_d;
    logic [31:0] out_c_q, out_c_d;
    logic [7:0]  out_ctl_q, out_ctl_d;
    logic        out_is_err_q, out_is_err_d;
    logic        out_valid_q, out_valid_d;
    logic        busy_q, busy_d;

    logic        accept;
    logic        out_hs;
    logic        crc_bad;
    logic        pkt_bad;
    logic [7:0]  err_code;

    // Gated by rst_n so nothing is accepted while reset is held, yet
    // ready is up in the very first cycle after release.
    assign in_ready = (state_q == S_IDLE) && rst_n;
    assign accept   = in_valid && in_ready;
    assign out_hs   = out_valid_q && out_ready;

    assign crc_bad = crc4({pkt_b_q, pkt_a_q, 1'b1, pkt_op_q}) != pkt_crc_q;
    assign pkt_bad = pkt_err_q || crc_bad || !op_legal(pkt_op_q);

    // Data error beats CRC error beats opcode error.
    always_comb begin
        err_code = ERR_OP;
        if (pkt_err_q) begin
            err_code = ERR_DATA;
        end else if (crc_bad) begin
            err_code = ERR_CRC;
        end
    end

    always_comb begin
        state_d      = state_q;
        pkt_a_d      = pkt_a_q;
        pkt_b_d      = pkt_b_q;
        pkt_op_d     = pkt_op_q;
        pkt_crc_d    = pkt_crc_q;
        pkt_err_d    = pkt_err_q;
        core_a_d     = core_a_q;
        core_b_d     = core_b_q;
        core_ctl_d   = CTL_PASS;
        wait_d       = wait_q;
        out_c_d      = out_c_q;
        out_ctl_d    = out_ctl_q;
        out_is_err_d = out_is_err_q;

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    pkt_a_d   = in_a;
                    pkt_b_d   = in_b;
                    pkt_op_d  = in_op;
                    pkt_crc_d = in_crc;
                    pkt_err_d = in_err;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                if (pkt_bad) begin
                    out_c_d      = 32'h0;
                    out_ctl_d    = err_code;
                    out_is_err_d = 1'b1;
                    state_d      = S_HOLD;
                end else begin
                    // Operands are registered here so they are stable
                    // for the whole ISSUE cycle the core samples.
                    core_a_d   = pkt_a_q;
                    core_b_d   = pkt_b_q;
                    core_ctl_d = {1'b0, pkt_op_q, pkt_crc_q};
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_d  = LAT;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wait_q <= 4'd1) begin
                    out_c_d      = core_c;
                    out_ctl_d    = core_ctl_out;
                    out_is_err_d = 1'b0;
                    state_d      = S_HOLD;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        out_valid_d = (state_d == S_HOLD);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pkt_a_q      <= 32'h0;
            pkt_b_q      <= 32'h0;
            pkt_op_q     <= 3'h0;
            pkt_crc_q    <= 4'h0;
            pkt_err_q    <= 1'b0;
            core_a_q     <= 32'h0;
            core_b_q     <= 32'h0;
            core_ctl_q   <= CTL_PASS;
            wait_q       <= 4'h0;
            out_c_q      <= 32'h0;
            out_ctl_q    <= 8'h0;
            out_is_err_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pkt_a_q      <= pkt_a_d;
            pkt_b_q      <= pkt_b_d;
            pkt_op_q     <= pkt_op_d;
            pkt_crc_q    <= pkt_crc_d;
            pkt_err_q    <= pkt_err_d;
            core_a_q     <= core_a_d;
            core_b_q     <= core_b_d;
            core_ctl_q   <= core_ctl_d;
            wait_q       <= wait_d;
            out_c_q      <= out_c_d;
            out_ctl_q    <= out_ctl_d;
            out_is_err_q <= out_is_err_d;
            out_valid_q  <= out_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign core_a     = core_a_q;
    assign core_b     = core_b_q;
    assign core_ctl   = core_ctl_q;
    assign out_c      = out_c_q;
    assign out_ctl    = out_ctl_q;
    assign out_is_err = out_is_err_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;

`ifdef MTM_ALU_SEQ_STATS_EN
    logic [15:0] op_cnt_q, op_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    // Saturating counts of completed responses, cleared only by reset.
    always_comb begin
        op_cnt_d  = op_cnt_q;
        err_cnt_d = err_cnt_q;
        if (out_hs) begin
            if (out_is_err_q) begin
                if (err_cnt_q != 16'hFFFF) begin
                    err_cnt_d = err_cnt_q + 16'd1;
                end
            end else begin
                if (op_cnt_q != 16'hFFFF) begin
                    op_cnt_d = op_cnt_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt_q  <= 16'h0;
            err_cnt_q <= 16'h0;
        end else begin
            op_cnt_q  <= op_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign op_cnt  = op_cnt_q;
    assign err_cnt = err_cnt_q;
`else
    logic unused_hs;
    assign unused_hs = out_hs;
    assign op_cnt    = 16'h0;
    assign err_cnt   = 16'h0;
`endif

endmodule
